sramlike_arbiter: RTL and testbench

SRAMLIKE_ARBITER -- requirements
Module: sramlike_arbiter

---
 rtl/sramlike_arbiter.sv | 132 +++++++++++++
 tb/tb_sramlike_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sramlike_arbiter.sv
// Two-master to one-slave sram-like arbiter with at most one outstanding transaction.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration. The default build gives the data master fixed priority.
//
//   state | meaning
//   IDLE  | no transaction; arbitrate pending master requests
//   ADDR  | granted master's request presented to slave, waiting addr_ok
//   DATA  | address accepted, waiting slave data_ok
module sramlike_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state, state_next;
    logic   gnt, gnt_next;
    logic   done;

    // A transaction completes on data_ok in DATA, or when addr_ok and data_ok arrive together in ADDR.
    assign done = ((state == ADDR) && addr_ok && data_ok) ||
                  ((state == DATA) && data_ok);

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_ptr;   // 0: inst preferred on the next contention, 1: data preferred

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (done) begin
            rr_ptr <= ~gnt;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= 1'b0;
        end else begin
            state <= state_next;
            gnt   <= gnt_next;
        end
    end

    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        case (state)
            IDLE: begin
                if (inst_req || data_req) begin
                    state_next = ADDR;
                    if (inst_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                        gnt_next = rr_ptr;
`else
                        gnt_next = 1'b1;
`endif
                    end else begin
                        gnt_next = data_req;
                    end
                end
            end
            ADDR: begin
                if (addr_ok) begin
                    state_next = data_ok ? IDLE : DATA;
                end
            end
            DATA: begin
                if (data_ok) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The slave request fields follow the granted master. They are only meaningful while req is high.
    assign wr    = gnt ? data_wr    : inst_wr;
    assign size  = gnt ? data_size  : inst_size;
    assign addr  = gnt ? data_addr  : inst_addr;
    assign wdata = gnt ? data_wdata : inst_wdata;

    assign inst_rdata = rdata;
    assign data_rdata = rdata;

    always_comb begin
        req          = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        if (state == ADDR) begin
            req          = 1'b1;
            inst_addr_ok = addr_ok && !gnt;
            data_addr_ok = addr_ok &&  gnt;
        end
        inst_data_ok = done && !gnt;
        data_data_ok = done &&  gnt;
    end

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Directed self-checking bench for sramlike_arbiter. Its expectations follow ARB_ROUND_ROBIN_EN
// when the bench and the design are built with the same macro setting.
module tb_sramlike_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_fail   = 0;

    sramlike_arbiter dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reports all four master handshakes packed as {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}.
    function automatic logic [31:0] hs();
        return {28'd0, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
        addr_ok = 0; data_ok = 0; rdata = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    logic [31:0] first_addr, second_addr, first_wr;
    logic [31:0] rr_order [4];

    initial begin
        clear_inputs();
        inst_req = 1; data_req = 1; addr_ok = 1; data_ok = 1;
        #12;
        check_val("rst_req", {31'd0, req}, 32'd0);
        check_val("rst_handshakes", hs(), 32'd0);
        clear_inputs();
        do_reset();

        // Single inst read: addr_ok at cycle 2, data_ok at cycle 4
        inst_req = 1; inst_addr = 32'hBFC00000;
        @(negedge clk); check_val("t1_c0_req", {31'd0, req}, 32'd0);
        cyc();
        @(negedge clk); check_val("t1_c1_req", {31'd0, req}, 32'd1);
        check_val("t1_c1_addr", addr, 32'hBFC00000);
        check_val("t1_c1_hs", hs(), 32'd0);
        cyc(); addr_ok = 1;
        @(negedge clk); check_val("t1_c2_req", {31'd0, req}, 32'd1);
        check_val("t1_c2_hs", hs(), 32'b1000);
        cyc(); inst_req = 0; addr_ok = 0;
        @(negedge clk); check_val("t1_c3_req", {31'd0, req}, 32'd0);
        check_val("t1_c3_hs", hs(), 32'd0);
        cyc(); data_ok = 1; rdata = 32'h3C08BFAF;
        @(negedge clk); check_val("t1_c4_hs", hs(), 32'b0100);
        check_val("t1_c4_rdata", inst_rdata, 32'h3C08BFAF);
        cyc(); data_ok = 0;
        @(negedge clk); check_val("t1_c5_req", {31'd0, req}, 32'd0);

        // Contention with addr_ok and data_ok arriving together
        clear_inputs(); do_reset();
`ifdef ARB_ROUND_ROBIN_EN
        first_addr = 32'h1000; second_addr = 32'h2000; first_wr = 0;
`else
        first_addr = 32'h2000; second_addr = 32'h1000; first_wr = 1;
`endif
        inst_req = 1; inst_addr = 32'h1000;
        data_req = 1; data_addr = 32'h2000; data_wr = 1; data_wdata = 32'hDEADBEEF;
        cyc(); addr_ok = 1; data_ok = 1;
        @(negedge clk); check_val("t2_first_addr", addr, first_addr);
        check_val("t2_first_wr", {31'd0, wr}, first_wr);
        check_val("t2_first_hs", hs(), (first_wr != 0) ? 32'b0011 : 32'b1100);
        cyc(); addr_ok = 0; data_ok = 0;
        if (first_wr != 0) data_req = 0; else inst_req = 0;
        @(negedge clk); check_val("t2_idle_req", {31'd0, req}, 32'd0);
        cyc(); addr_ok = 1;
        @(negedge clk); check_val("t2_second_addr", addr, second_addr);
        check_val("t2_second_req", {31'd0, req}, 32'd1);
        cyc(); inst_req = 0; data_req = 0; addr_ok = 0; data_ok = 1;
        @(negedge clk); check_val("t2_second_hs", hs(), (first_wr != 0) ? 32'b0100 : 32'b0001);
        cyc(); data_ok = 1;
        @(negedge clk); check_val("t2_spurious_hs", hs(), 32'd0);
        data_ok = 0;

        // Slave stalls addr_ok while data master requests mid-grant
        clear_inputs(); do_reset();
        inst_req = 1; inst_addr = 32'h3000;
        data_addr = 32'h4000;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            if (i == 2) data_req = 1;
            @(negedge clk);
            check_val("t3_stall_addr", addr, 32'h3000);
            check_val("t3_stall_hs", hs(), 32'd0);
        end
        cyc(); addr_ok = 1;
        @(negedge clk); check_val("t3_accept_hs", hs(), 32'b1000);
        cyc(); addr_ok = 0; inst_req = 0;
        @(negedge clk); check_val("t3_data_req", {31'd0, req}, 32'd0);
        cyc(); data_ok = 1;
        @(negedge clk); check_val("t3_done_hs", hs(), 32'b0100);
        cyc(); data_ok = 0;
        cyc(); addr_ok = 1; data_ok = 1;
        @(negedge clk); check_val("t3_data_addr", addr, 32'h4000);
        check_val("t3_data_hs", hs(), 32'b0011);
        cyc(); clear_inputs();

        // Reset asserted while waiting in DATA
        inst_req = 1; inst_addr = 32'h5000;
        cyc(); addr_ok = 1;
        cyc(); inst_req = 0; addr_ok = 0;
        @(negedge clk);
        data_ok = 1; rst = 1; #2;
        check_val("t4_rst_hs", hs(), 32'd0);
        check_val("t4_rst_req", {31'd0, req}, 32'd0);
        @(posedge clk); #1; rst = 0;
        @(negedge clk); check_val("t4_after_hs", hs(), 32'd0);
        cyc(); data_ok = 0; inst_req = 1; inst_addr = 32'h6000;
        cyc(); addr_ok = 1; data_ok = 1;
        @(negedge clk); check_val("t4_next_addr", addr, 32'h6000);
        check_val("t4_next_hs", hs(), 32'b1100);
        cyc(); clear_inputs();

        // Continuous contention over four transactions
        do_reset();
`ifdef ARB_ROUND_ROBIN_EN
        rr_order = '{32'h1000, 32'h2000, 32'h1000, 32'h2000};
`else
        rr_order = '{32'h2000, 32'h2000, 32'h2000, 32'h2000};
`endif
        inst_req = 1; inst_addr = 32'h1000;
        data_req = 1; data_addr = 32'h2000;
        for (int i = 0; i < 4; i++) begin
            cyc(); addr_ok = 1; data_ok = 1;
            @(negedge clk); check_val($sformatf("t5_grant%0d", i), addr, rr_order[i]);
            cyc(); addr_ok = 0; data_ok = 0;
            @(negedge clk); check_val($sformatf("t5_idle%0d", i), {31'd0, req}, 32'd0);
        end
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
